// File: rtl/pause_scheduler_pkg.sv
// Purpose : shared types and helpers for the CPU-pause scheduler.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_e (FSM encoding), TO_W (timeout counter width), to_cycles() (ms -> clk_sys cycles).
package pause_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_GRANT   = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam int TO_W = 32;

  // Grant hold limit in clk_sys cycles for a clock of 'mhz' MHz.
  function automatic logic [TO_W-1:0] to_cycles(input int ms, input int mhz);
    return TO_W'(ms * mhz * 1000);
  endfunction

endpackage

// File: rtl/pause_scheduler_if.sv
// Purpose : requester/video side bundle of the pause scheduler.
// Latency : n/a (wires only).
// Backpr. : none; req is a level, grant is held until the owner drops req.
// Ports   : req, vblank (master -> slave); grant, owner_id, pause_cpu, timeout (slave -> master).
interface pause_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic            vblank;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  owner_id;
  logic            pause_cpu;
  logic            timeout;

  modport master (output req, vblank, input grant, owner_id, pause_cpu, timeout);
  modport slave  (input req, vblank, output grant, owner_id, pause_cpu, timeout);
endinterface

// File: rtl/pause_scheduler_prio_enc.sv
// Purpose : lowest-index-wins priority encoder over the effective request vector.
// Latency : combinational.
// Backpr. : none.
// Ports   : req_i (requests), valid_o (any set), idx_o (winner index), onehot_o (winner one-hot).
module pause_prio_enc #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  output logic            valid_o,
  output logic [IDW-1:0]  idx_o,
  output logic [NREQ-1:0] onehot_o
);

  assign valid_o  = |req_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = req_i & (~req_i + NREQ'(1));

  always_comb begin
    idx_o = '0;
    // Scan downwards so the lowest set index is written last and wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/pause_scheduler.sv
// Purpose : arbitrates CPU-pause ownership; vblank-aligned pause entry, exclusive one-hot grant.
// Latency : req to grant/pause_cpu 1 cycle after next vblank rise (2 cycles if VB_SYNC=0); owner drop to resume 2 cycles.
// Backpr. : no preemption; owner keeps grant while its req is high (bounded by timeout when PAUSE_SCHED_TIMEOUT_EN).
// Ports   : clk_sys, reset (sync, active-high), bus (pause_scheduler_if.slave).
// Config  : `define PAUSE_SCHED_TIMEOUT_EN enables the grant hold timeout and block mask.
import pause_sched_pkg::*;

module pause_scheduler #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int VB_SYNC    = 1,
  parameter int CLKSPD     = 12,
  parameter int TIMEOUT_MS = 2000
) (
  input logic               clk_sys,
  input logic               reset,
  pause_scheduler_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_WAIT_VB = ST_WAIT_VB;
  localparam logic [1:0] S_GRANT   = ST_GRANT;
  localparam logic [1:0] S_GAP     = ST_GAP;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            pause_q, pause_d;
  logic            vblank_q;
  logic            vb_rise;
  logic [NREQ-1:0] eff_req;
  logic            enc_vld;
  logic [IDW-1:0]  enc_idx;
  logic [NREQ-1:0] enc_onehot;

`ifdef PAUSE_SCHED_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = to_cycles(TIMEOUT_MS, CLKSPD);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] block_q, block_d;
  logic            timeout_q, timeout_d;
`endif

  assign vb_rise = bus.vblank & ~vblank_q;

`ifdef PAUSE_SCHED_TIMEOUT_EN
  assign eff_req = bus.req & ~block_q;
`else
  assign eff_req = bus.req;
`endif

  pause_prio_enc #(.NREQ(NREQ), .IDW(IDW)) u_enc (
    .req_i    (eff_req),
    .valid_o  (enc_vld),
    .idx_o    (enc_idx),
    .onehot_o (enc_onehot)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    pause_d = pause_q;
`ifdef PAUSE_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    // A blocked requester is released as soon as it lets go of req.
    block_d   = block_q & bus.req;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Always pass through WAIT_VB; with VB_SYNC=0 it is left on the next
        // edge, which gives the 2-cycle unsynchronised entry latency.
        if (enc_vld) state_d = S_WAIT_VB;
      end
      S_WAIT_VB: begin
        if (!enc_vld) begin
          state_d = S_IDLE;
        end else if (vb_rise || (VB_SYNC == 0)) begin
          state_d = S_GRANT;
          grant_d = enc_onehot;
          owner_d = enc_idx;
          pause_d = 1'b1;
`ifdef PAUSE_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!bus.req[owner_q]) begin
          state_d = S_GAP;
          grant_d = '0;
`ifdef PAUSE_SCHED_TIMEOUT_EN
        end else if (cnt_q == TO_LIMIT - 1'b1) begin
          // Forced revoke: the owner stays locked out until it drops req.
          state_d   = S_GAP;
          grant_d   = '0;
          block_d   = block_d | grant_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_GAP: begin
        // Hand over while the CPU is still halted; no vblank re-sync needed.
        if (enc_vld) begin
          state_d = S_GRANT;
          grant_d = enc_onehot;
          owner_d = enc_idx;
`ifdef PAUSE_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_IDLE;
          pause_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      pause_q   <= 1'b0;
      vblank_q  <= 1'b0;
`ifdef PAUSE_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
      block_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      pause_q   <= pause_d;
      vblank_q  <= bus.vblank;
`ifdef PAUSE_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
      block_q   <= block_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner_id  = owner_q;
  assign bus.pause_cpu = pause_q;
`ifdef PAUSE_SCHED_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
